// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The slave side is the adder; the master side supplies operands and consumes results.
interface serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Add/subtract unit that processes one CHUNK-bit slice per cycle, LSB first,
// with the inter-slice carry held in a register. Result held in DONE until taken.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_if.slave   bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
    $error("serial_adder: WIDTH must be >= 1 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CHUNK:0]   slice_s;
  logic [31:0]      base_s;

  // Next-state, slice arithmetic and registered-output decode
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    co_d      = co_q;
    ovf_d     = ovf_q;
    base_s    = 32'(cnt_q) * 32'(CHUNK);
    slice_s   = {1'b0, a_q[base_s +: CHUNK]} + {1'b0, b_q[base_s +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is a + ~b + !borrow_in, so both are folded in at accept time
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.ci ^ bus.sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d[base_s +: CHUNK] = slice_s[CHUNK-1:0];
        carry_d                = slice_s[CHUNK];
        if (cnt_q == LAST) begin
          co_d    = slice_s[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[CHUNK-1] != a_q[WIDTH-1]);
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Drives three serial_adder instances (CHUNK = 4, 16, 1) with identical operands and
// compares results and latency against an integer-arithmetic reference model.
module tb_serial_adder;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, ci, sub, out_ready;
  logic [W-1:0] a, b;

  logic [2:0]   in_ready_s, out_valid_s, co_s, ovf_s;
  logic [W-1:0] sum_s [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int C = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
    serial_adder_if #(.WIDTH(W)) ifc ();
    assign ifc.in_valid  = in_valid;
    assign ifc.a         = a;
    assign ifc.b         = b;
    assign ifc.ci        = ci;
    assign ifc.sub       = sub;
    assign ifc.out_ready = out_ready;
    assign in_ready_s[g]  = ifc.in_ready;
    assign out_valid_s[g] = ifc.out_valid;
    assign sum_s[g]       = ifc.sum;
    assign co_s[g]        = ifc.co;
    assign ovf_s[g]       = ifc.ovf;
    serial_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
    );
  end

  function automatic int exp_lat(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 1 : 16);
  endfunction

  // Reference: plain signed/unsigned integer arithmetic on the operands
  function automatic vec_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mci, input logic msub);
    vec_t r;
    int ua, ub, sa, sb, u, s;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (!msub) begin
      u    = ua + ub + int'(mci);
      s    = sa + sb + int'(mci);
      r.co = (u > 65535);
    end else begin
      u    = ua - ub - int'(mci);
      s    = sa - sb - int'(mci);
      r.co = (u >= 0);
    end
    r.a   = ma;
    r.b   = mb;
    r.ci  = mci;
    r.sub = msub;
    r.sum = u[W-1:0];
    r.ovf = (s > 32767) || (s < -32768);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One operation on all three units; optional stall in DONE with in_valid toggling
  task automatic run_op(input vec_t v, input int stall);
    int lat [3];
    bit all_v;
    chk("in_ready_before_op", 32'(in_ready_s), 32'h7);
    a = v.a; b = v.b; ci = v.ci; sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
    lat = '{0, 0, 0};
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      all_v = 1'b1;
      for (int g = 0; g < 3; g++) begin
        if (out_valid_s[g] && lat[g] == 0) lat[g] = cyc;
        if (lat[g] == 0) all_v = 1'b0;
      end
      if (all_v) break;
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("latency_u%0d", g), 32'(lat[g]), 32'(exp_lat(g)));
      chk($sformatf("sum_u%0d", g), 32'(sum_s[g]), 32'(v.sum));
      chk($sformatf("co_u%0d", g), 32'(co_s[g]), 32'(v.co));
      chk($sformatf("ovf_u%0d", g), 32'(ovf_s[g]), 32'(v.ovf));
    end
    for (int k = 0; k < stall; k++) begin
      in_valid = k[0] ? 1'b0 : 1'b1;
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      chk("stall_out_valid", 32'(out_valid_s), 32'h7);
      chk("stall_in_ready", 32'(in_ready_s), 32'h0);
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("stall_sum_u%0d", g), 32'(sum_s[g]), 32'(v.sum));
        chk($sformatf("stall_flags_u%0d", g), 32'({co_s[g], ovf_s[g]}), 32'({v.co, v.ovf}));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_take", 32'(out_valid_s), 32'h0);
    chk("in_ready_after_take", 32'(in_ready_s), 32'h7);
  endtask

  vec_t vecs [5];
  vec_t v;

  initial begin
    vecs[0] = '{a: 16'hFFFF, b: 16'h0001, ci: 1'b0, sub: 1'b0, sum: 16'h0000, co: 1'b1, ovf: 1'b0};
    vecs[1] = '{a: 16'h7FFF, b: 16'h0001, ci: 1'b1, sub: 1'b0, sum: 16'h8001, co: 1'b0, ovf: 1'b1};
    vecs[2] = '{a: 16'h0005, b: 16'h0007, ci: 1'b0, sub: 1'b1, sum: 16'hFFFE, co: 1'b0, ovf: 1'b0};
    vecs[3] = '{a: 16'h8000, b: 16'h0001, ci: 1'b0, sub: 1'b1, sum: 16'h7FFF, co: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 16'h1234, b: 16'h4321, ci: 1'b0, sub: 1'b0, sum: 16'h5555, co: 1'b0, ovf: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 16'h0; b = 16'h0; ci = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_out_valid", 32'(out_valid_s), 32'h0);
    chk("reset_in_ready", 32'(in_ready_s), 32'h7);
    chk("reset_co", 32'(co_s), 32'h0);
    chk("reset_ovf", 32'(ovf_s), 32'h0);
    for (int g = 0; g < 3; g++) chk($sformatf("reset_sum_u%0d", g), 32'(sum_s[g]), 32'h0);

    for (int i = 0; i < 5; i++) run_op(vecs[i], 0);

    // Stall in DONE with new operands offered, then confirm none were taken
    run_op(vecs[1], 5);
    run_op(vecs[2], 0);

    // Reset while the CHUNK=4 unit is at its third slice
    a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", 32'(out_valid_s), 32'h0);
    chk("midrun_rst_in_ready", 32'(in_ready_s), 32'h7);
    for (int g = 0; g < 3; g++) chk($sformatf("midrun_rst_sum_u%0d", g), 32'(sum_s[g]), 32'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(vecs[4], 0);

    for (int i = 0; i < 1000; i++) begin
      v = model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      run_op(v, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
